gmem_axi_mem_responder: RTL and testbench



---
 rtl/gmem_axi_mem_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_gmem_axi_mem_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmem_axi_mem_responder.sv
// AXI4 slave that services m_axi_gmem INCR bursts from an internal word-addressed RAM,
// one transaction at a time, answering DECERR for beats that fall outside its window.
module gmem_axi_mem_responder #(
    parameter int          C_M_AXI_GMEM_ADDR_WIDTH = 64,
    parameter int          C_M_AXI_GMEM_DATA_WIDTH = 32,
    parameter int          C_M_AXI_GMEM_ID_WIDTH   = 1,
    parameter int          C_MEM_DEPTH             = 1024,
    parameter logic [63:0] C_BASE_ADDR             = 64'h0
) (
    input  logic                               ap_clk,
    input  logic                               areset,
    // write address
    input  logic                               s_axi_gmem_AWVALID,
    output logic                               s_axi_gmem_AWREADY,
    input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0] s_axi_gmem_AWADDR,
    input  logic [C_M_AXI_GMEM_ID_WIDTH-1:0]   s_axi_gmem_AWID,
    input  logic [7:0]                         s_axi_gmem_AWLEN,
    input  logic [2:0]                         s_axi_gmem_AWSIZE,
    input  logic [1:0]                         s_axi_gmem_AWBURST,
    input  logic                               s_axi_gmem_AWLOCK,
    input  logic [3:0]                         s_axi_gmem_AWCACHE,
    input  logic [2:0]                         s_axi_gmem_AWPROT,
    input  logic [3:0]                         s_axi_gmem_AWQOS,
    input  logic [3:0]                         s_axi_gmem_AWREGION,
    // write data
    input  logic                               s_axi_gmem_WVALID,
    output logic                               s_axi_gmem_WREADY,
    input  logic [C_M_AXI_GMEM_DATA_WIDTH-1:0] s_axi_gmem_WDATA,
    input  logic [C_M_AXI_GMEM_DATA_WIDTH/8-1:0] s_axi_gmem_WSTRB,
    input  logic                               s_axi_gmem_WLAST,
    // write response
    output logic                               s_axi_gmem_BVALID,
    input  logic                               s_axi_gmem_BREADY,
    output logic [1:0]                         s_axi_gmem_BRESP,
    output logic [C_M_AXI_GMEM_ID_WIDTH-1:0]   s_axi_gmem_BID,
    // read address
    input  logic                               s_axi_gmem_ARVALID,
    output logic                               s_axi_gmem_ARREADY,
    input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0] s_axi_gmem_ARADDR,
    input  logic [C_M_AXI_GMEM_ID_WIDTH-1:0]   s_axi_gmem_ARID,
    input  logic [7:0]                         s_axi_gmem_ARLEN,
    input  logic [2:0]                         s_axi_gmem_ARSIZE,
    input  logic [1:0]                         s_axi_gmem_ARBURST,
    input  logic                               s_axi_gmem_ARLOCK,
    input  logic [3:0]                         s_axi_gmem_ARCACHE,
    input  logic [2:0]                         s_axi_gmem_ARPROT,
    input  logic [3:0]                         s_axi_gmem_ARQOS,
    input  logic [3:0]                         s_axi_gmem_ARREGION,
    // read data
    output logic                               s_axi_gmem_RVALID,
    input  logic                               s_axi_gmem_RREADY,
    output logic [C_M_AXI_GMEM_DATA_WIDTH-1:0] s_axi_gmem_RDATA,
    output logic [1:0]                         s_axi_gmem_RRESP,
    output logic                               s_axi_gmem_RLAST,
    output logic [C_M_AXI_GMEM_ID_WIDTH-1:0]   s_axi_gmem_RID
);

    localparam int AW    = C_M_AXI_GMEM_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_GMEM_DATA_WIDTH;
    localparam int IW    = C_M_AXI_GMEM_ID_WIDTH;
    localparam int NB    = DW / 8;
    localparam int BSH   = $clog2(NB);
    localparam int IDX_W = $clog2(C_MEM_DEPTH);

    // Beat addresses carry one extra bit so a burst running off the top of
    // the address space still compares as out of range instead of wrapping.
    localparam logic [AW:0] BASE_X = {1'b0, C_BASE_ADDR[AW-1:0]};
    localparam logic [AW:0] TOP_X  = BASE_X + (AW+1)'(C_MEM_DEPTH * NB);
    localparam logic [AW:0] BPB_X  = (AW+1)'(NB);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic       PREF_RD     = 1'b0;
    localparam logic       PREF_WR     = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_WRESP} state_t;

    state_t          state_reg;
    logic            pref_reg;
    logic [AW:0]     rd_addr_reg;
    logic [7:0]      rd_len_reg;
    logic [8:0]      rd_cnt_reg;
    logic [AW:0]     wr_addr_reg;
    logic [7:0]      wr_len_reg;
    logic [7:0]      wr_cnt_reg;
    logic            wr_err_reg;
    logic            rvalid_reg;
    logic            rlast_reg;
    logic [1:0]      rresp_reg;
    logic [IW-1:0]   rid_reg;
    logic            bvalid_reg;
    logic [1:0]      bresp_reg;
    logic [IW-1:0]   bid_reg;

    logic [DW-1:0]   mem [C_MEM_DEPTH];
    logic [DW-1:0]   ram_q_reg;

    logic            ar_accept;
    logic            aw_accept;
    logic            rd_issue;
    logic            rd_in_range;
    logic            wr_in_range;
    logic            wr_fire;
    logic [AW:0]     rd_off;
    logic [AW:0]     wr_off;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] ram_idx;
    logic [NB-1:0]   wr_be;

    assign ar_accept = !areset && (state_reg == ST_IDLE) && s_axi_gmem_ARVALID &&
                       (!s_axi_gmem_AWVALID || pref_reg == PREF_RD);
    assign aw_accept = !areset && (state_reg == ST_IDLE) && s_axi_gmem_AWVALID &&
                       (!s_axi_gmem_ARVALID || pref_reg == PREF_WR);

    assign rd_in_range = (rd_addr_reg >= BASE_X) && (rd_addr_reg < TOP_X);
    assign wr_in_range = (wr_addr_reg >= BASE_X) && (wr_addr_reg < TOP_X);
    assign rd_off      = rd_addr_reg - BASE_X;
    assign wr_off      = wr_addr_reg - BASE_X;
    assign rd_idx      = rd_off[BSH +: IDX_W];
    assign wr_idx      = wr_off[BSH +: IDX_W];

    // A new beat is fetched whenever the output slot is empty or being drained.
    assign rd_issue = (state_reg == ST_RD) && (rd_cnt_reg <= {1'b0, rd_len_reg}) &&
                      (!rvalid_reg || s_axi_gmem_RREADY);
    assign wr_fire  = !areset && (state_reg == ST_WR) && s_axi_gmem_WVALID;
    assign ram_idx  = (state_reg == ST_WR) ? wr_idx : rd_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte_en
            assign wr_be[gi] = wr_fire && wr_in_range && s_axi_gmem_WSTRB[gi];
        end
    endgenerate

    always_ff @(posedge ap_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                mem[ram_idx][b*8 +: 8] <= s_axi_gmem_WDATA[b*8 +: 8];
            end
        end
        if (rd_issue) begin
            ram_q_reg <= mem[ram_idx];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_reg   <= ST_IDLE;
            pref_reg    <= PREF_RD;
            rd_addr_reg <= '0;
            rd_len_reg  <= '0;
            rd_cnt_reg  <= '0;
            wr_addr_reg <= '0;
            wr_len_reg  <= '0;
            wr_cnt_reg  <= '0;
            wr_err_reg  <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rid_reg     <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            bid_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ar_accept) begin
                        state_reg   <= ST_RD;
                        pref_reg    <= PREF_WR;
                        rd_addr_reg <= {1'b0, s_axi_gmem_ARADDR};
                        rd_len_reg  <= s_axi_gmem_ARLEN;
                        rd_cnt_reg  <= '0;
                        rid_reg     <= s_axi_gmem_ARID;
                    end else if (aw_accept) begin
                        state_reg   <= ST_WR;
                        pref_reg    <= PREF_RD;
                        wr_addr_reg <= {1'b0, s_axi_gmem_AWADDR};
                        wr_len_reg  <= s_axi_gmem_AWLEN;
                        wr_cnt_reg  <= '0;
                        wr_err_reg  <= 1'b0;
                        bid_reg     <= s_axi_gmem_AWID;
                    end
                end
                ST_RD: begin
                    if (rd_issue) begin
                        rvalid_reg  <= 1'b1;
                        rresp_reg   <= rd_in_range ? RESP_OKAY : RESP_DECERR;
                        rlast_reg   <= (rd_cnt_reg[7:0] == rd_len_reg);
                        rd_cnt_reg  <= rd_cnt_reg + 9'd1;
                        rd_addr_reg <= rd_addr_reg + BPB_X;
                    end else if (rvalid_reg && s_axi_gmem_RREADY) begin
                        // only the final beat can drain without a successor
                        rvalid_reg <= 1'b0;
                        rlast_reg  <= 1'b0;
                        rresp_reg  <= RESP_OKAY;
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (s_axi_gmem_WVALID) begin
                        if (!wr_in_range) begin
                            wr_err_reg <= 1'b1;
                        end
                        wr_addr_reg <= wr_addr_reg + BPB_X;
                        wr_cnt_reg  <= wr_cnt_reg + 8'd1;
                        if (wr_cnt_reg == wr_len_reg) begin
                            state_reg  <= ST_WRESP;
                            bvalid_reg <= 1'b1;
                            bresp_reg  <= (wr_err_reg || !wr_in_range) ? RESP_DECERR : RESP_OKAY;
                        end
                    end
                end
                ST_WRESP: begin
                    if (s_axi_gmem_BREADY) begin
                        bvalid_reg <= 1'b0;
                        bresp_reg  <= RESP_OKAY;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign s_axi_gmem_ARREADY = ar_accept;
    assign s_axi_gmem_AWREADY = aw_accept;
    assign s_axi_gmem_WREADY  = (state_reg == ST_WR);
    assign s_axi_gmem_BVALID  = bvalid_reg;
    assign s_axi_gmem_BRESP   = bresp_reg;
    assign s_axi_gmem_BID     = bid_reg;
    assign s_axi_gmem_RVALID  = rvalid_reg;
    assign s_axi_gmem_RLAST   = rlast_reg;
    assign s_axi_gmem_RRESP   = rresp_reg;
    assign s_axi_gmem_RID     = rid_reg;
    // RAM output register is not reset, so mask it outside valid OKAY beats
    assign s_axi_gmem_RDATA   = (rvalid_reg && rresp_reg == RESP_OKAY) ? ram_q_reg : '0;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_gmem_AWSIZE, s_axi_gmem_AWBURST, s_axi_gmem_AWLOCK,
                         s_axi_gmem_AWCACHE, s_axi_gmem_AWPROT, s_axi_gmem_AWQOS,
                         s_axi_gmem_AWREGION, s_axi_gmem_ARSIZE, s_axi_gmem_ARBURST,
                         s_axi_gmem_ARLOCK, s_axi_gmem_ARCACHE, s_axi_gmem_ARPROT,
                         s_axi_gmem_ARQOS, s_axi_gmem_ARREGION, s_axi_gmem_WLAST,
                         rd_off, wr_off};

endmodule

// File: tb/tb_gmem_axi_mem_responder.sv
// Directed bench for gmem_axi_mem_responder: bursts, strobes, backpressure,
// window edges, arbitration and reset recovery.
module tb_gmem_axi_mem_responder;

    logic        clk;
    logic        areset;
    logic        awvalid, awready;
    logic [63:0] awaddr;
    logic [0:0]  awid;
    logic [7:0]  awlen;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [0:0]  bid;
    logic        arvalid, arready;
    logic [63:0] araddr;
    logic [0:0]  arid;
    logic [7:0]  arlen;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [0:0]  rid;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wbuf      [256];
    logic [3:0]  sbuf      [256];
    logic [31:0] rexp      [256];
    logic [1:0]  rresp_exp [256];

    gmem_axi_mem_responder dut (
        .ap_clk              (clk),
        .areset              (areset),
        .s_axi_gmem_AWVALID  (awvalid),
        .s_axi_gmem_AWREADY  (awready),
        .s_axi_gmem_AWADDR   (awaddr),
        .s_axi_gmem_AWID     (awid),
        .s_axi_gmem_AWLEN    (awlen),
        .s_axi_gmem_AWSIZE   (3'd2),
        .s_axi_gmem_AWBURST  (2'b01),
        .s_axi_gmem_AWLOCK   (1'b0),
        .s_axi_gmem_AWCACHE  (4'b0011),
        .s_axi_gmem_AWPROT   (3'b000),
        .s_axi_gmem_AWQOS    (4'b0000),
        .s_axi_gmem_AWREGION (4'b0000),
        .s_axi_gmem_WVALID   (wvalid),
        .s_axi_gmem_WREADY   (wready),
        .s_axi_gmem_WDATA    (wdata),
        .s_axi_gmem_WSTRB    (wstrb),
        .s_axi_gmem_WLAST    (wlast),
        .s_axi_gmem_BVALID   (bvalid),
        .s_axi_gmem_BREADY   (bready),
        .s_axi_gmem_BRESP    (bresp),
        .s_axi_gmem_BID      (bid),
        .s_axi_gmem_ARVALID  (arvalid),
        .s_axi_gmem_ARREADY  (arready),
        .s_axi_gmem_ARADDR   (araddr),
        .s_axi_gmem_ARID     (arid),
        .s_axi_gmem_ARLEN    (arlen),
        .s_axi_gmem_ARSIZE   (3'd2),
        .s_axi_gmem_ARBURST  (2'b01),
        .s_axi_gmem_ARLOCK   (1'b0),
        .s_axi_gmem_ARCACHE  (4'b0011),
        .s_axi_gmem_ARPROT   (3'b000),
        .s_axi_gmem_ARQOS    (4'b0000),
        .s_axi_gmem_ARREGION (4'b0000),
        .s_axi_gmem_RVALID   (rvalid),
        .s_axi_gmem_RREADY   (rready),
        .s_axi_gmem_RDATA    (rdata),
        .s_axi_gmem_RRESP    (rresp),
        .s_axi_gmem_RLAST    (rlast),
        .s_axi_gmem_RID      (rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // All tasks begin and end one time unit after a rising edge.
    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check_eq({tag, "_arready"}, 64'(arready), 64'd0);
        check_eq({tag, "_awready"}, 64'(awready), 64'd0);
        check_eq({tag, "_wready"},  64'(wready),  64'd0);
        check_eq({tag, "_bvalid"},  64'(bvalid),  64'd0);
        check_eq({tag, "_rvalid"},  64'(rvalid),  64'd0);
        check_eq({tag, "_rlast"},   64'(rlast),   64'd0);
        check_eq({tag, "_rdata"},   64'(rdata),   64'd0);
        check_eq({tag, "_rresp"},   64'(rresp),   64'd0);
        check_eq({tag, "_bresp"},   64'(bresp),   64'd0);
        check_eq({tag, "_rid"},     64'(rid),     64'd0);
        check_eq({tag, "_bid"},     64'(bid),     64'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
    endtask

    task automatic aw_phase(input logic [63:0] addr, input logic [7:0] len, input logic [0:0] id);
        int guard = 0;
        awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("aw_accept", 64'(awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [63:0] addr, input logic [7:0] len, input logic [0:0] id);
        int guard = 0;
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ar_accept", 64'(arready), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic w_phase(input int len, input logic rnd);
        int i = 0;
        int guard = 0;
        logic first = 1'b1;
        while (i <= len && guard < 4000) begin
            wvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdata  = wbuf[i];
            wstrb  = sbuf[i];
            wlast  = (i == len);
            @(negedge clk);
            if (first) begin
                check_eq("wready_t1", 64'(wready), 64'd1);
                first = 1'b0;
            end
            if (wvalid && wready) i++;
            @(posedge clk); #1;
            guard++;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        check_eq("w_beats", 64'(i), 64'(len + 1));
    endtask

    task automatic b_phase(input logic [1:0] exp_resp, input logic [0:0] exp_id, input logic rnd);
        int wait_n;
        int waited = 0;
        int guard = 0;
        wait_n = rnd ? int'($urandom_range(1, 4)) : 0;
        bready = !rnd;
        @(negedge clk);
        check_eq("bvalid_u1", 64'(bvalid), 64'd1);
        while (!(bvalid && bready) && guard < 20) begin
            @(posedge clk); #1;
            waited++;
            if (waited >= wait_n) bready = 1'b1;
            @(negedge clk);
            check_eq("bvalid_hold", 64'(bvalid), 64'd1);
            guard++;
        end
        check_eq("bresp", 64'(bresp), 64'(exp_resp));
        check_eq("bid", 64'(bid), 64'(exp_id));
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic r_phase(input int len, input logic rnd, input logic [0:0] exp_id);
        int beat = 0;
        int cyc = 1;
        int guard = 0;
        int first = -1;
        logic prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic prev_last = 1'b0;
        while (beat <= len && guard < 4000) begin
            rready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (prev_stall) begin
                check_eq("rdata_stable", 64'(rdata), 64'(prev_data));
                check_eq("rlast_stable", 64'(rlast), 64'(prev_last));
            end
            if (rvalid && first < 0) begin
                first = cyc;
                check_eq("r_latency", 64'(cyc), 64'd2);
            end
            if (rvalid && rready) begin
                check_eq("rdata", 64'(rdata), 64'(rexp[beat]));
                check_eq("rresp", 64'(rresp), 64'(rresp_exp[beat]));
                check_eq("rlast", 64'(rlast), 64'(beat == len));
                check_eq("rid", 64'(rid), 64'(exp_id));
                if (!rnd && beat == len) check_eq("r_end_cycle", 64'(cyc), 64'(2 + len));
                beat++;
            end
            prev_stall = rvalid && !rready;
            prev_data  = rdata;
            prev_last  = rlast;
            @(posedge clk); #1;
            cyc++;
            guard++;
        end
        rready = 1'b0;
        check_eq("r_beats", 64'(beat), 64'(len + 1));
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [0:0] id,
                            input logic rnd, input logic [1:0] exp_resp);
        aw_phase(addr, len, id);
        w_phase(int'(len), rnd);
        b_phase(exp_resp, id, rnd);
        $display("write addr=%h len=%0d id=%0d expect_bresp=%0d", addr, len, id, exp_resp);
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [0:0] id,
                           input logic rnd);
        ar_phase(addr, len, id);
        r_phase(int'(len), rnd, id);
        $display("read  addr=%h len=%0d id=%0d", addr, len, id);
    endtask

    initial begin
        areset = 1'b1;
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; rready = 0;
        for (int i = 0; i < 256; i++) begin
            wbuf[i] = '0; sbuf[i] = 4'hF; rexp[i] = '0; rresp_exp[i] = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        check_reset_outputs("rst0");

        // 4-beat write then read back from address 0
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'h11111111 * (i + 1); sbuf[i] = 4'hF;
            rexp[i] = 32'h11111111 * (i + 1); rresp_exp[i] = 2'b00;
        end
        do_write(64'h0, 8'd3, 1'b1, 1'b0, 2'b00);
        do_read(64'h0, 8'd3, 1'b1, 1'b0);

        // byte strobes on word 5
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hF;
        do_write(64'h14, 8'd0, 1'b0, 1'b0, 2'b00);
        wbuf[0] = 32'h11223344; sbuf[0] = 4'b0101;
        do_write(64'h14, 8'd0, 1'b0, 1'b0, 2'b00);
        rexp[0] = 32'hAA22CC44; rresp_exp[0] = 2'b00;
        do_read(64'h14, 8'd0, 1'b0, 1'b0);

        // 256-beat burst with random backpressure
        for (int i = 0; i < 256; i++) begin
            wbuf[i] = 32'h5A000000 + 32'(i) * 32'h00010203; sbuf[i] = 4'hF;
            rexp[i] = 32'h5A000000 + 32'(i) * 32'h00010203; rresp_exp[i] = 2'b00;
        end
        do_write(64'h100, 8'd255, 1'b1, 1'b1, 2'b00);
        do_read(64'h100, 8'd255, 1'b1, 1'b1);

        // burst straddling the top of the window
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'hE0E0E000 + 32'(i); sbuf[i] = 4'hF;
        end
        do_write(64'hFF8, 8'd3, 1'b0, 1'b0, 2'b11);
        rexp[0] = 32'hE0E0E000; rresp_exp[0] = 2'b00;
        rexp[1] = 32'hE0E0E001; rresp_exp[1] = 2'b00;
        rexp[2] = 32'h0;        rresp_exp[2] = 2'b11;
        rexp[3] = 32'h0;        rresp_exp[3] = 2'b11;
        do_read(64'hFF8, 8'd3, 1'b0, 1'b0);
        rexp[0] = 32'h11111111; rresp_exp[0] = 2'b00;
        rexp[1] = 32'h22222222; rresp_exp[1] = 2'b00;
        do_read(64'h0, 8'd1, 1'b1, 1'b0);

        // simultaneous AW/AR after reset: read, write, read
        reset_pulse();
        araddr = 64'h0; arlen = 8'd0; arid = 1'b0; arvalid = 1'b1;
        awaddr = 64'h40; awlen = 8'd0; awid = 1'b1; awvalid = 1'b1;
        @(negedge clk);
        check_eq("coll1_arready", 64'(arready), 64'd1);
        check_eq("coll1_awready", 64'(awready), 64'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        rexp[0] = 32'h11111111; rresp_exp[0] = 2'b00;
        r_phase(0, 1'b0, 1'b0);
        $display("read  addr=%h len=0 id=0 (collision 1)", 64'h0);
        araddr = 64'h4; arlen = 8'd0; arid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        check_eq("coll2_awready", 64'(awready), 64'd1);
        check_eq("coll2_arready", 64'(arready), 64'd0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wbuf[0] = 32'hC0FFEE01; sbuf[0] = 4'hF;
        w_phase(0, 1'b0);
        b_phase(2'b00, 1'b1, 1'b0);
        $display("write addr=%h len=0 id=1 (collision 2)", 64'h40);
        awaddr = 64'h44; awlen = 8'd0; awid = 1'b0; awvalid = 1'b1;
        @(negedge clk);
        check_eq("coll3_arready", 64'(arready), 64'd1);
        check_eq("coll3_awready", 64'(awready), 64'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        rexp[0] = 32'h22222222; rresp_exp[0] = 2'b00;
        r_phase(0, 1'b0, 1'b1);
        $display("read  addr=%h len=0 id=1 (collision 3)", 64'h4);
        aw_phase(64'h44, 8'd0, 1'b0);
        wbuf[0] = 32'hC0FFEE02;
        w_phase(0, 1'b0);
        b_phase(2'b00, 1'b0, 1'b0);
        $display("write addr=%h len=0 id=0", 64'h44);
        rexp[0] = 32'hC0FFEE01; rexp[1] = 32'hC0FFEE02;
        rresp_exp[0] = 2'b00; rresp_exp[1] = 2'b00;
        do_read(64'h40, 8'd1, 1'b0, 1'b0);

        // reset during beat 2 of an 8-beat read, then a fresh read
        ar_phase(64'h0, 8'd7, 1'b1);
        rready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        areset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_beat2", 64'(rdata), 64'h33333333);
        @(posedge clk); #1;
        areset = 1'b0;
        rready = 1'b0;
        $display("read  addr=%h len=7 id=1 abandoned by reset", 64'h0);
        check_reset_outputs("rst_mid");
        for (int i = 0; i < 4; i++) begin
            rexp[i] = 32'h11111111 * (i + 1); rresp_exp[i] = 2'b00;
        end
        do_read(64'h0, 8'd3, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
